// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU control codes, datapath widths
// and the EX/MEM buffer entry layout.
package cpu_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_BEQ  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_BGT  = 4'b1001;
  localparam logic [3:0] ALU_BNE  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_BNEZ = 4'b1100;
  localparam logic [3:0] ALU_BGEZ = 4'b1101;

  typedef struct packed {
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] store;
    logic [REG_W-1:0]  rd;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
  } entry_t;

  typedef enum logic [1:0] {
    BUF_EMPTY,
    BUF_ONE,
    BUF_TWO
  } buf_state_e;

endpackage

// File: rtl/ex_branch_cmp.sv
// Branch condition resolution from raw ALU operands.
// Purely combinational; unknown codes resolve to not-taken.
module ex_branch_cmp
  import cpu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [3:0]   ctrl,
  input  logic [W-1:0] src1,
  input  logic [W-1:0] src2,
  output logic         taken
);

  always_comb begin
    taken = 1'b0;
    unique case (ctrl)
      ALU_BEQ:  taken = (src1 == src2);
      ALU_BNE:  taken = (src1 != src2);
      ALU_BGT:  taken = ($signed(src1) > $signed(src2));
      ALU_BNEZ: taken = (src1 != '0);
      ALU_BGEZ: taken = ~src1[W-1];
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM stage: 2-entry elastic buffer with valid/ready on both
// sides, plus branch resolution and a registered taken pulse.
module ex_mem_stage
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [3:0]        ctrl_i,
  input  logic              branch_i,
  input  logic [DATA_W-1:0] branch_target_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [REG_W-1:0]  rd_i,
  input  logic              reg_write_i,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic              mem_to_reg_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_result_o,
  output logic [DATA_W-1:0] out_store_o,
  output logic [REG_W-1:0]  out_rd_o,
  output logic              out_reg_write_o,
  output logic              out_mem_read_o,
  output logic              out_mem_write_o,
  output logic              out_mem_to_reg_o,
  output logic              branch_taken_o,
  output logic [DATA_W-1:0] branch_target_o
);

  buf_state_e        state_q, state_d;
  entry_t            head_q, head_d;
  entry_t            skid_q, skid_d;
  entry_t            new_e;
  logic              in_ready_q;
  logic              taken_q, taken_d;
  logic [DATA_W-1:0] target_q, target_d;
  logic              cmp_taken;
  logic              accept;
  logic              emit;

  ex_branch_cmp #(
    .W (DATA_W)
  ) u_cmp (
    .ctrl  (ctrl_i),
    .src1  (src1_i),
    .src2  (src2_i),
    .taken (cmp_taken)
  );

  assign accept = in_valid_i & in_ready_q & ~flush_i;
  assign emit   = out_valid_o & out_ready_i;

  // Branches carry no architectural side effect past this stage.
  always_comb begin
    new_e            = '0;
    new_e.result     = alu_result_i;
    new_e.store      = store_data_i;
    new_e.rd         = rd_i;
    new_e.reg_write  = reg_write_i & ~branch_i;
    new_e.mem_read   = mem_read_i & ~branch_i;
    new_e.mem_write  = mem_write_i & ~branch_i;
    new_e.mem_to_reg = mem_to_reg_i;
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = BUF_EMPTY;
      head_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        BUF_EMPTY: begin
          if (accept) begin
            state_d = BUF_ONE;
            head_d  = new_e;
          end
        end
        BUF_ONE: begin
          if (accept && emit) begin
            head_d = new_e;
          end else if (accept) begin
            state_d = BUF_TWO;
            skid_d  = new_e;
          end else if (emit) begin
            state_d = BUF_EMPTY;
            head_d  = '0;
          end
        end
        BUF_TWO: begin
          if (emit) begin
            state_d = BUF_ONE;
            head_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = BUF_EMPTY;
          head_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    taken_d  = accept & branch_i & cmp_taken;
    target_d = taken_d ? branch_target_i : '0;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= BUF_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      taken_q    <= 1'b0;
      target_q   <= '0;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != BUF_TWO);
      taken_q    <= taken_d;
      target_q   <= target_d;
    end
  end

  assign in_ready_o       = in_ready_q;
  assign out_valid_o      = (state_q != BUF_EMPTY);
  assign out_result_o     = head_q.result;
  assign out_store_o      = head_q.store;
  assign out_rd_o         = head_q.rd;
  assign out_reg_write_o  = head_q.reg_write;
  assign out_mem_read_o   = head_q.mem_read;
  assign out_mem_write_o  = head_q.mem_write;
  assign out_mem_to_reg_o = head_q.mem_to_reg;
  assign branch_taken_o   = taken_q;
  assign branch_target_o  = target_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Directed bench for ex_mem_stage: streaming, backpressure,
// branch resolution, flush and asynchronous reset.
module tb_ex_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] alu_result;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [3:0]  ctrl;
  logic        branch;
  logic [31:0] btarget;
  logic [31:0] store_data;
  logic [4:0]  rd;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [31:0] out_store;
  logic [4:0]  out_rd;
  logic        out_reg_write;
  logic        out_mem_read;
  logic        out_mem_write;
  logic        out_mem_to_reg;
  logic        br_taken;
  logic [31:0] br_target;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .alu_result_i     (alu_result),
    .src1_i           (src1),
    .src2_i           (src2),
    .ctrl_i           (ctrl),
    .branch_i         (branch),
    .branch_target_i  (btarget),
    .store_data_i     (store_data),
    .rd_i             (rd),
    .reg_write_i      (reg_write),
    .mem_read_i       (mem_read),
    .mem_write_i      (mem_write),
    .mem_to_reg_i     (mem_to_reg),
    .flush_i          (flush),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_result_o     (out_result),
    .out_store_o      (out_store),
    .out_rd_o         (out_rd),
    .out_reg_write_o  (out_reg_write),
    .out_mem_read_o   (out_mem_read),
    .out_mem_write_o  (out_mem_write),
    .out_mem_to_reg_o (out_mem_to_reg),
    .branch_taken_o   (br_taken),
    .branch_target_o  (br_target)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [31:0] res,
                     input logic [3:0] c, input logic b,
                     input logic [31:0] s1, input logic [31:0] s2);
    in_valid   = v;
    alu_result = res;
    ctrl       = c;
    branch     = b;
    src1       = s1;
    src2       = s2;
    btarget    = 32'h40;
    store_data = res ^ 32'hFFFF_0000;
    rd         = res[4:0];
    reg_write  = 1'b1;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0]  bc  [5];
  logic [31:0] bs1 [5];
  logic [31:0] bs2 [5];
  logic        bex [5];

  initial begin
    bc[0] = 4'b0111; bs1[0] = 32'd5;          bs2[0] = 32'd5; bex[0] = 1'b1;
    bc[1] = 4'b1010; bs1[1] = 32'd5;          bs2[1] = 32'd5; bex[1] = 1'b0;
    bc[2] = 4'b1001; bs1[2] = 32'hFFFF_FFFF;  bs2[2] = 32'd3; bex[2] = 1'b0;
    bc[3] = 4'b1101; bs1[3] = 32'd0;          bs2[3] = 32'd0; bex[3] = 1'b1;
    bc[4] = 4'b1100; bs1[4] = 32'h8000_0000;  bs2[4] = 32'd0; bex[4] = 1'b1;

    rst       = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drv(1'b0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0);
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_taken", {31'd0, br_taken}, 32'd0);
    chk("rst_target", br_target, 32'd0);
    chk("rst_result", out_result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Streaming: one result per cycle.
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 32'd100 + i, 4'b0000, 1'b0, 32'd1, 32'd2);
      tick();
      chk($sformatf("str_valid%0d", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("str_res%0d", i), out_result, 32'd100 + i);
      chk($sformatf("str_rdy%0d", i), {31'd0, in_ready}, 32'd1);
    end
    chk("str_rw", {31'd0, out_reg_write}, 32'd1);
    drv(1'b0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0);
    tick();
    chk("str_drain", {31'd0, out_valid}, 32'd0);

    // Backpressure: fill both entries, then drain in order.
    out_ready = 1'b0;
    drv(1'b1, 32'hA, 4'b0000, 1'b0, 32'd0, 32'd0);
    tick();
    chk("bp_rdyA", {31'd0, in_ready}, 32'd1);
    chk("bp_headA", out_result, 32'hA);
    drv(1'b1, 32'hB, 4'b0000, 1'b0, 32'd0, 32'd0);
    tick();
    chk("bp_rdyB", {31'd0, in_ready}, 32'd0);
    chk("bp_headA2", out_result, 32'hA);
    drv(1'b1, 32'hC, 4'b0000, 1'b0, 32'd0, 32'd0);
    tick();
    chk("bp_holdC", out_result, 32'hA);
    chk("bp_storeA", out_store, 32'hFFFF_000A);
    drv(1'b0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_headB", out_result, 32'hB);
    chk("bp_validB", {31'd0, out_valid}, 32'd1);
    chk("bp_rdy_back", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // Branch resolution, each followed by an idle cycle.
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, 32'd0, bc[i], 1'b1, bs1[i], bs2[i]);
      tick();
      chk($sformatf("br%0d_taken", i), {31'd0, br_taken}, {31'd0, bex[i]});
      chk($sformatf("br%0d_tgt", i), br_target, bex[i] ? 32'h40 : 32'd0);
      chk($sformatf("br%0d_rw", i), {31'd0, out_reg_write}, 32'd0);
      chk($sformatf("br%0d_valid", i), {31'd0, out_valid}, 32'd1);
      drv(1'b0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0);
      tick();
      chk($sformatf("br%0d_pulse_end", i), {31'd0, br_taken}, 32'd0);
    end

    // Flush in TWO with an incoming taken BEQ.
    out_ready = 1'b0;
    drv(1'b1, 32'h11, 4'b0000, 1'b0, 32'd0, 32'd0);
    tick();
    drv(1'b1, 32'h22, 4'b0000, 1'b0, 32'd0, 32'd0);
    tick();
    chk("fl_two", {31'd0, in_ready}, 32'd0);
    drv(1'b1, 32'd0, 4'b0111, 1'b1, 32'd5, 32'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl_valid", {31'd0, out_valid}, 32'd0);
    chk("fl_taken", {31'd0, br_taken}, 32'd0);
    chk("fl_rdy", {31'd0, in_ready}, 32'd1);
    chk("fl_result", out_result, 32'd0);

    // Flush from EMPTY drops an acceptable taken branch.
    drv(1'b1, 32'd0, 4'b0111, 1'b1, 32'd5, 32'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("fl2_valid", {31'd0, out_valid}, 32'd0);
    chk("fl2_taken", {31'd0, br_taken}, 32'd0);

    // Asynchronous reset in TWO with a pending pulse.
    drv(1'b1, 32'h33, 4'b0000, 1'b0, 32'd0, 32'd0);
    tick();
    drv(1'b1, 32'h44, 4'b0111, 1'b1, 32'd5, 32'd5);
    tick();
    chk("ar_pre_taken", {31'd0, br_taken}, 32'd1);
    chk("ar_pre_rdy", {31'd0, in_ready}, 32'd0);
    drv(1'b0, 32'd0, 4'b0000, 1'b0, 32'd0, 32'd0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_valid", {31'd0, out_valid}, 32'd0);
    chk("ar_rdy", {31'd0, in_ready}, 32'd1);
    chk("ar_taken", {31'd0, br_taken}, 32'd0);
    chk("ar_target", br_target, 32'd0);
    chk("ar_result", out_result, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    chk("ar_post_rdy", {31'd0, in_ready}, 32'd1);
    chk("ar_post_valid", {31'd0, out_valid}, 32'd0);

    // First accept right after release.
    out_ready = 1'b1;
    drv(1'b1, 32'h55, 4'b0000, 1'b0, 32'd0, 32'd0);
    tick();
    chk("post_acc", out_result, 32'h55);
    chk("post_rd", {27'd0, out_rd}, 32'h15);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage placed directly downstream of the ALU. It captures the ALU result and the ID/EX control bundle into a 2-entry elastic buffer with valid/ready handshakes on both sides, so that a stalling data memory does not lose instructions. It also resolves branch conditions from the raw operands: the ALU drives `result_o` = 0 for all branch codes, so branch decisions cannot come from the ALU. It signals taken branches to fetch.

## Interface
- `DATA_W`, 32, datapath width
- `REG_W`, 5, register index width
- `clk_i` in 1 — single clock, rising edge
- `rst_i` in 1 — asynchronous, active-low reset
- `in_valid_i` in 1 — EX bundle valid
- `in_ready_o` out 1 — stage can accept
- `alu_result_i` in DATA_W — ALU `result_o`
- `src1_i`, `src2_i` in DATA_W — ALU operands, used for branch compare
- `ctrl_i` in 4 — ALU control code
- `branch_i` in 1 — instruction is a branch
- `branch_target_i` in DATA_W — precomputed target PC
- `store_data_i` in DATA_W — rt value for `sw`
- `rd_i` in REG_W — destination register
- `reg_write_i`, `mem_read_i`, `mem_write_i`, `mem_to_reg_i` in 1 each — control bits
- `flush_i` in 1 — hazard/exception kill of stage contents
- `out_valid_o` out 1 / `out_ready_i` in 1 — MEM-side handshake
- `out_result_o`, `out_store_o` out DATA_W; `out_rd_o` out REG_W
- `out_reg_write_o`, `out_mem_read_o`, `out_mem_write_o`, `out_mem_to_reg_o` out 1 each
- `branch_taken_o` out 1 — registered one-cycle pulse
- `branch_target_o` out DATA_W — valid while `branch_taken_o` = 1

## Operation
- Accept when `in_valid_i & in_ready_o & !flush_i`. Emit when `out_valid_o & out_ready_i`.
- Buffer FSM, states EMPTY, ONE, TWO:
  - EMPTY: accept → ONE.
  - ONE: accept only → TWO; emit only → EMPTY; accept and emit → ONE, new entry becomes head.
  - TWO: emit → ONE, skid entry moves to head; no accept is possible.
- `in_ready_o` = (state != TWO), driven from a register.
- `out_valid_o` = (state != EMPTY). All out_* fields come from the head entry.
- Branch compare on `src1_i`/`src2_i` at accept. Signed compares use two's complement.
  - 0111 BEQ: equal.
  - 1010 BNE: not equal.
  - 1001 BGT: src1 > src2, signed.
  - 1100 BNEZ: src1 != 0.
  - 1101 BGEZ: src1[31] == 0.
  - Any other code with `branch_i` = 1: not taken.
- An accepted branch is stored with `reg_write`, `mem_read` and `mem_write` forced to 0. It still occupies an entry and drains as a bubble.
- Taken at accept: `branch_taken_o` = 1 on the next cycle only, with `branch_target_o` = latched target. Otherwise both are 0.
- `flush_i`:
  - Highest priority; clears both entries → EMPTY.
  - Drops the same-cycle accept, including its branch pulse.
  - Does not cancel a pulse already registered.
- Simultaneous `flush_i` and emit: the emit completes, then the buffer is empty.

## Timing
- Latency: accept at edge N → `out_valid_o` high after edge N, with no bubble when the buffer is EMPTY.
- Throughput: 1 per cycle while `out_ready_i` = 1.
- `in_ready_o` deasserts the cycle after the buffer reaches TWO. No combinational path from `out_ready_i` to `in_ready_o`.
- Reset (asynchronous, any time, including mid-transfer):
  - state EMPTY, all entries and out_* = 0.
  - `out_valid_o` = 0, `in_ready_o` = 1.
  - `branch_taken_o` = 0, `branch_target_o` = 0.
- First accept is allowed on the first rising edge after `rst_i` rises.

## Structure
- Shared package `cpu_pkg`: ALU control code constants (0000–1101, incl. BEQ/BGT/BNE/BNEZ/BGEZ), `DATA_W`/`REG_W` defaults, and the stage-entry packed struct (result, store, rd, four control bits).
- Sub-module `ex_branch_cmp`: combinational; inputs `ctrl`, `src1`, `src2`; output `taken`.
- The buffer FSM and registers live in `ex_mem_stage`.

## Test plan
- Streaming: 4 back-to-back `add` accepts with `out_ready_i` = 1 → 4 outputs on consecutive cycles with matching results; `in_ready_o` stays 1.
- Backpressure: `out_ready_i` = 0, push A and B → `in_ready_o` = 0 after B; raise ready → A then B emitted in order, nothing lost.
- Branches: BEQ with 5/5, BNE with 5/5, BGT with -1/3, BGEZ with 0, BNEZ with 0x8000_0000, each with target 0x40.
  - Expected `branch_taken_o`: 1, 0, 0, 1, 1.
  - Target 0x40 when taken.
  - Each entry emitted with `reg_write` = 0.
- Flush: `flush_i` in state TWO, together with an incoming taken BEQ → EMPTY next cycle, no branch pulse, `out_valid_o` = 0.
- Reset mid-operation: drop `rst_i` in state TWO with a pending branch pulse → all outputs 0 immediately, asynchronously; after release, `in_ready_o` = 1.
